// File: rtl/pong_pkg.sv
// Shared Pong geometry, derived ball limits, controller state encoding and
// the paddle/ball vertical overlap test.
package pong_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BALL_PX  = 16;
    localparam int PAD_W    = 8;
    localparam int PAD_H    = 64;
    localparam int PAD_L_X  = 16;
    localparam int PAD_R_X  = 616;

    localparam int CENTER_X = (SCREEN_W - BALL_PX) / 2;
    localparam int CENTER_Y = (SCREEN_H - BALL_PX) / 2;
    localparam int LIMIT_X  = SCREEN_W - BALL_PX;
    localparam int LIMIT_Y  = SCREEN_H - BALL_PX;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        SCORED
    } state_t;

    // True when a ball whose top row is by shares any row with a paddle whose top row is py.
    function automatic logic v_overlap(input logic [9:0] by, input logic [9:0] py,
                                       input int bsz, input int ph);
        logic [10:0] b;
        logic [10:0] p;
        b = {1'b0, by};
        p = {1'b0, py};
        return ((b + 11'(bsz)) > p) && (b < (p + 11'(ph)));
    endfunction

endpackage

// File: rtl/pong_axis_step.sv
// One-axis ball step: next position saturated into 0..MAXV, and a flag
// for crossing the lo face (moving down in value) or hi face (moving up).
module pong_axis_step #(
    parameter int MAXV    = 624,
    parameter bit LO_INCL = 1'b1,
    parameter bit HI_INCL = 1'b1
) (
    input  logic [9:0] pos,
    input  logic       dir,
    input  logic [3:0] speed,
    input  logic [9:0] lo,
    input  logic [9:0] hi,
    output logic [9:0] nxt,
    output logic       bounce
);
    localparam logic signed [10:0] MAXS = 11'(MAXV);

    logic signed [10:0] p, s, l, h, raw;

    always_comb begin
        p   = signed'({1'b0, pos});
        s   = signed'({7'd0, speed});
        l   = signed'({1'b0, lo});
        h   = signed'({1'b0, hi});
        raw = dir ? (p + s) : (p - s);

        if (raw <= 11'sd0)
            nxt = '0;
        else if (raw >= MAXS)
            nxt = 10'(MAXV);
        else
            nxt = raw[9:0];

        // Only a ball starting on the near side of a face can cross it.
        if (dir)
            bounce = (p <= h) && (HI_INCL ? (raw >= h) : (raw > h));
        else
            bounce = (p >= l) && (LO_INCL ? (raw <= l) : (raw < l));
    end
endmodule

// File: rtl/pong_ball_ctrl.sv
// Frame-rate ball motion: serve/play/hold sequencing, wall and paddle
// bounces, miss detection and rally speed-up.
module pong_ball_ctrl
    import pong_pkg::*;
#(
    parameter int H_ACTIVE      = SCREEN_W,
    parameter int V_ACTIVE      = SCREEN_H,
    parameter int BALL_SIZE     = BALL_PX,
    parameter int PADDLE_W      = PAD_W,
    parameter int PADDLE_H      = PAD_H,
    parameter int PADDLE_L_X    = PAD_L_X,
    parameter int PADDLE_R_X    = PAD_R_X,
    parameter int SPEED_INIT    = 2,
    parameter int SPEED_MAX     = 6,
    parameter int HITS_PER_STEP = 4,
    parameter int HOLD_FRAMES   = 60
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       in_play,
    output logic       hit,
    output logic       score_l,
    output logic       score_r
);
    localparam int XMAX_I = H_ACTIVE - BALL_SIZE;
    localparam int YMAX_I = V_ACTIVE - BALL_SIZE;
    localparam int HIT_W  = $clog2(HITS_PER_STEP + 1);
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [9:0] CX       = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] CY       = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] XMAX     = 10'(XMAX_I);
    localparam logic [9:0] YMAX     = 10'(YMAX_I);
    localparam logic [9:0] FACE_L   = 10'(PADDLE_L_X + PADDLE_W);
    localparam logic [9:0] FACE_R   = 10'(PADDLE_R_X - BALL_SIZE);
    localparam logic [3:0] SPD_INIT = 4'(SPEED_INIT);
    localparam logic [3:0] SPD_MAX  = 4'(SPEED_MAX);
    localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(HITS_PER_STEP - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    state_t            state;
    logic              dx, dy;
    logic [3:0]        speed;
    logic [HIT_W-1:0]  hit_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [9:0]        x_nxt, y_nxt;
    logic              x_face, y_wall, ovl_l, ovl_r, hit_now;

    pong_axis_step #(.MAXV(YMAX_I), .LO_INCL(1'b1), .HI_INCL(1'b1)) u_step_y (
        .pos(ball_y), .dir(dy), .speed(speed), .lo(10'd0), .hi(YMAX),
        .nxt(y_nxt), .bounce(y_wall)
    );

    // Left face must be strictly passed to hit; the right face counts on contact.
    pong_axis_step #(.MAXV(XMAX_I), .LO_INCL(1'b0), .HI_INCL(1'b1)) u_step_x (
        .pos(ball_x), .dir(dx), .speed(speed), .lo(FACE_L), .hi(FACE_R),
        .nxt(x_nxt), .bounce(x_face)
    );

    assign ovl_l   = v_overlap(ball_y, paddle_l_y, BALL_SIZE, PADDLE_H);
    assign ovl_r   = v_overlap(ball_y, paddle_r_y, BALL_SIZE, PADDLE_H);
    assign hit_now = x_face && (dx ? ovl_r : ovl_l);

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            ball_x   <= CX;
            ball_y   <= CY;
            dx       <= 1'b1;
            dy       <= 1'b1;
            speed    <= SPD_INIT;
            hit_cnt  <= '0;
            hold_cnt <= '0;
            in_play  <= 1'b0;
            hit      <= 1'b0;
            score_l  <= 1'b0;
            score_r  <= 1'b0;
        end else begin
            hit     <= 1'b0;
            score_l <= 1'b0;
            score_r <= 1'b0;
            case (state)
                IDLE: begin
                    ball_x   <= CX;
                    ball_y   <= CY;
                    speed    <= SPD_INIT;
                    hit_cnt  <= '0;
                    hold_cnt <= '0;
                    if (serve) begin
                        state   <= PLAY;
                        in_play <= 1'b1;
                    end
                end
                PLAY: if (frame_tick) begin
                    ball_y <= y_nxt;
                    if (y_wall)
                        dy <= ~dy;
                    if (hit_now) begin
                        ball_x <= dx ? FACE_R : FACE_L;
                        dx     <= ~dx;
                        hit    <= 1'b1;
                        if (hit_cnt == HIT_LAST) begin
                            hit_cnt <= '0;
                            if (speed < SPD_MAX)
                                speed <= speed + 4'd1;
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end else begin
                        ball_x <= x_nxt;
                        // Next serve heads toward whoever just lost the point.
                        if (dx && x_nxt == XMAX) begin
                            score_l <= 1'b1;
                            dx      <= 1'b1;
                            state   <= SCORED;
                            in_play <= 1'b0;
                        end else if (!dx && x_nxt == 10'd0) begin
                            score_r <= 1'b1;
                            dx      <= 1'b0;
                            state   <= SCORED;
                            in_play <= 1'b0;
                        end
                    end
                end
                SCORED: if (frame_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        ball_x   <= CX;
                        ball_y   <= CY;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Scoreboarded bench for pong_ball_ctrl: a behavioural model predicts every
// cycle's outputs, plus fixed-value checks at the notable moments of a game.
module tb_pong_ball_ctrl;
    logic       vga_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] paddle_l_y = '0;
    logic [9:0] paddle_r_y = '0;
    logic [9:0] ball_x, ball_y;
    logic       in_play, hit, score_l, score_r;

    always #5 vga_clk = ~vga_clk;

    pong_ball_ctrl dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .frame_tick(frame_tick), .serve(serve),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(ball_x), .ball_y(ball_y), .in_play(in_play),
        .hit(hit), .score_l(score_l), .score_r(score_r)
    );

    int checks = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    // Model state: mst 0 = idle, 1 = play, 2 = scored
    int   mx, my, mspd, mhits, mhold, mst;
    logic mdx, mdy, mhit, msl, msr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic ft, input logic sv, input logic rst);
        int   nx, pad;
        logic ovl;
        mhit = 1'b0; msl = 1'b0; msr = 1'b0;
        if (rst) begin
            mx = 312; my = 232; mdx = 1'b1; mdy = 1'b1;
            mspd = 2; mhits = 0; mhold = 0; mst = 0;
        end else if (mst == 0) begin
            mx = 312; my = 232; mhits = 0; mspd = 2; mhold = 0;
            if (sv) mst = 1;
        end else if (mst == 1 && ft) begin
            pad = mdx ? int'(paddle_r_y) : int'(paddle_l_y);
            ovl = (my + 16 > pad) && (my < pad + 64);
            if (mdy) begin
                if (my + mspd >= 464) begin my = 464; mdy = 1'b0; end
                else my = my + mspd;
            end else begin
                if (my <= mspd) begin my = 0; mdy = 1'b1; end
                else my = my - mspd;
            end
            if (mdx) begin
                nx = mx + mspd;
                if (mx <= 600 && nx >= 600 && ovl) begin mx = 600; mdx = 1'b0; mhit = 1'b1; end
                else if (nx >= 624) begin mx = 624; msl = 1'b1; mst = 2; end
                else mx = nx;
            end else begin
                nx = mx - mspd;
                if (mx >= 24 && nx < 24 && ovl) begin mx = 24; mdx = 1'b1; mhit = 1'b1; end
                else if (nx <= 0) begin mx = 0; msr = 1'b1; mdx = 1'b0; mst = 2; end
                else mx = nx;
            end
            if (mhit) begin
                mhits++;
                if (mhits == 4) begin
                    mhits = 0;
                    if (mspd < 6) mspd++;
                end
            end
        end else if (mst == 2 && ft) begin
            if (mhold == 59) begin mhold = 0; mx = 312; my = 232; mst = 0; end
            else mhold++;
        end
    endtask

    task automatic step(input logic ft, input logic sv, input logic rst);
        frame_tick = ft; serve = sv; sys_rst = rst;
        model_step(ft, sv, rst);
        exp_q.push_back({10'(mx), 10'(my), (mst == 1), mhit, msl, msr});
        @(posedge vga_clk);
        #1;
        check("cycle", {8'd0, ball_x, ball_y, in_play, hit, score_l, score_r},
              {8'd0, exp_q.pop_front()});
        frame_tick = 1'b0; serve = 1'b0; sys_rst = 1'b0;
    endtask

    // mode 0: both track; 1: right fixed at 380, left tracks; 2: right avoids; 3: both avoid
    task automatic pads(input int mode);
        int trk, avd;
        trk = (my <= 416) ? my : 416;
        avd = (my < 240) ? 416 : 0;
        paddle_l_y = 10'((mode == 3) ? avd : trk);
        paddle_r_y = 10'((mode == 1) ? 380 : ((mode == 0) ? trk : avd));
    endtask

    task automatic tick(input int mode);
        step(1'b0, 1'b0, 1'b0);
        pads(mode);
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, guard, h, d, px;
        logic seen;

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("rst_x", ball_x, 312);
        check("rst_y", ball_y, 232);
        check("rst_flags", {in_play, hit, score_l, score_r}, 0);

        step(1'b1, 1'b0, 1'b0);
        check("idle_tick_x", ball_x, 312);
        step(1'b0, 1'b1, 1'b0);

        n = 0;
        repeat (3) begin tick(1); n++; end
        check("serve3_x", ball_x, 318);
        check("serve3_y", ball_y, 238);
        check("serve3_play", in_play, 1);

        while (n < 116) begin tick(1); n++; end
        check("bottom_y", ball_y, 464);
        while (n < 144) begin tick(1); n++; end
        check("rhit_x", ball_x, 600);
        check("rhit_y", ball_y, 408);
        check("rhit_pulse", hit, 1);
        step(1'b0, 1'b0, 1'b0);
        check("rhit_one_cycle", hit, 0);
        pads(1);
        step(1'b1, 1'b0, 1'b0);
        check("after_hit_x", ball_x, 598);

        seen = 1'b0; guard = 0;
        while (!seen && guard < 2000) begin
            tick(2); guard++;
            seen = msl | msr;
        end
        check("miss_seen", seen, 1);
        check("miss_x", ball_x, 624);
        check("miss_score_l", score_l, 1);
        step(1'b0, 1'b0, 1'b0);
        check("score_one_cycle", score_l, 0);

        repeat (59) tick(2);
        check("hold_frozen_x", ball_x, 624);
        check("hold_not_play", in_play, 0);
        tick(2);
        check("hold_end_x", ball_x, 312);
        check("hold_end_y", ball_y, 232);
        step(1'b1, 1'b0, 1'b0);
        check("idle_again_x", ball_x, 312);
        step(1'b0, 1'b1, 1'b0);
        tick(0);
        check("reserve_right", ball_x, 314);

        h = 0; guard = 0;
        while (h < 20 && guard < 8000) begin
            tick(0); guard++;
            if (mhit) begin
                h++;
                px = int'(ball_x);
                if (h == 4 || h == 16 || h == 20) begin
                    tick(0);
                    d = (int'(ball_x) > px) ? int'(ball_x) - px : px - int'(ball_x);
                    check($sformatf("speed_after_%0d", h), d, (h == 4) ? 3 : 6);
                end
            end
        end
        check("rally_hits", h, 20);

        seen = 1'b0; guard = 0;
        while (!seen && guard < 2000) begin
            step(1'b0, 1'b0, 1'b0);
            pads(3);
            if (mdx ? (mx + mspd >= 624) : (mx <= mspd)) begin
                step(1'b1, 1'b0, 1'b1);
                seen = 1'b1;
            end else begin
                step(1'b1, 1'b0, 1'b0);
            end
            guard++;
        end
        check("rst_score_reached", seen, 1);
        check("rst_no_score", {score_l, score_r}, 0);
        check("rst_mid_x", ball_x, 312);
        check("rst_mid_y", ball_y, 232);
        check("rst_mid_play", in_play, 0);
        step(1'b1, 1'b0, 1'b0);
        check("rst_then_idle", ball_x, 312);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
